// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the MEM-stage load/store port.
// Serves one word access after LAT wait cycles and stalls the pipeline meanwhile.
module dmem_responder #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          rd_q;
    logic          wr_q;
    logic          mis_q;
    logic          ack_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    logic [31:0]   mem [DEPTH];

    logic          req;
    logic          fire;
    logic          do_wr;
    logic          unused_addr;

    assign req         = memread | memwrite;
    assign fire        = (state_q == BUSY) && (cnt_q == 4'd0);
    assign do_wr       = fire && wr_q && !mis_q;
    assign unused_addr = ^addr[31:AW+2];

    assign stall = ((state_q == IDLE) && req) || (state_q == BUSY);
    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (req) begin
                        idx_q   <= addr[AW+1:2];
                        wdata_q <= wdata;
                        rd_q    <= memread;
                        wr_q    <= memwrite;
                        mis_q   <= (addr[1:0] != 2'b00);
                        cnt_q   <= 4'(LAT - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                        err_q   <= mis_q | (rd_q & wr_q);
                        // a dual request is served as a write, so rdata keeps its value
                        if (rd_q && !wr_q) begin
                            rdata_q <= mis_q ? 32'd0 : mem[idx_q];
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The array has no reset; an async reset leaves BUSY before any write edge.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
